// File: rtl/trig_sched.sv
// trig_sched: trigger emulator, spill gating and pending-trigger tag FIFO
// that feeds the readout request/acknowledge handshake.
module trig_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigpulse,
  input  logic        cyclebegin,
  input  logic        cycleend,
  input  logic        emu_en,
  input  logic [15:0] emu_period,
  input  logic        rd_ack,
  output logic        trigemu,
  output logic        rd_req,
  output logic [7:0]  rd_tag,
  output logic        busy,
  output logic        incycle,
  output logic [15:0] trigcnt,
  output logic [15:0] lost
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [15:0]   emu_cnt;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [OW-1:0] occ;
  logic [OW-1:0] occ_nxt;
  logic          active;
  logic          accept;
  logic          pop;
  logic          push;
  logic          drop;
  logic [15:0]   cnt_base;
  logic [15:0]   lost_base;
  logic [7:0]    tag_in;
  logic [7:0]    tag_nxt;

  // cyclebegin opens the window in the same clock it arrives
  assign active = incycle | cyclebegin;
  assign accept = trigpulse & active;
  assign pop    = rd_req & rd_ack;
  assign push   = accept & (~busy | pop);
  assign drop   = accept & busy & ~pop;

  assign cnt_base  = cyclebegin ? 16'd0 : trigcnt;
  assign lost_base = cyclebegin ? 16'd0 : lost;
  assign tag_in    = cnt_base[7:0];

  assign occ_nxt    = occ + OW'(push) - OW'(pop);
  assign rd_ptr_nxt = rd_ptr + PW'(pop);

  // head bypass when the pushed tag lands in an otherwise empty FIFO
  always_comb begin
    tag_nxt = 8'd0;
    if (occ_nxt == '0)
      tag_nxt = 8'd0;
    else if (occ == OW'(pop))
      tag_nxt = tag_in;
    else
      tag_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= tag_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      incycle <= 1'b0;
      trigcnt <= 16'd0;
      lost    <= 16'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      rd_req  <= 1'b0;
      busy    <= 1'b0;
      rd_tag  <= 8'd0;
    end else begin
      if (cyclebegin)
        incycle <= 1'b1;
      else if (cycleend)
        incycle <= 1'b0;
      trigcnt <= cnt_base + 16'(push);
      if (drop && lost_base != 16'hFFFF)
        lost <= lost_base + 16'd1;
      else
        lost <= lost_base;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_nxt;
      occ    <= occ_nxt;
      rd_req <= (occ_nxt != '0);
      busy   <= (occ_nxt == FULL);
      rd_tag <= tag_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emu_cnt <= emu_period;
      trigemu <= 1'b0;
    end else if (!emu_en) begin
      emu_cnt <= emu_period;
      trigemu <= 1'b0;
    end else if (emu_cnt == 16'd0) begin
      emu_cnt <= emu_period;
      trigemu <= 1'b1;
    end else begin
      emu_cnt <= emu_cnt - 16'd1;
      trigemu <= 1'b0;
    end
  end

endmodule
